// File: rtl/fx2_in_scheduler_if.sv
// rtl/fx2_in_scheduler_if.sv - source/FX2 write-path bundle for fx2_in_scheduler
// Purpose: groups the sample source, reply source and FX2 slave-FIFO write
//          signals that pass through the IN scheduler.
// Signals:
//   sample_rdy/sample/sample_ack         sample byte source handshake
//   reply_rdy/reply/reply_end/reply_ack  reply byte source handshake
//   full_n                               FX2 FIFO not full (selected EP)
//   wr_en/wr_data/ep_adr/pktend          FX2 pin-logic write controls
// Modports: master = scheduler, slave = sources plus pin logic.
interface fx2_in_scheduler_if;
  logic       sample_rdy;
  logic [7:0] sample;
  logic       sample_ack;
  logic       reply_rdy;
  logic [7:0] reply;
  logic       reply_end;
  logic       reply_ack;
  logic       full_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [1:0] ep_adr;
  logic       pktend;

  modport master (
    input  sample_rdy, sample, reply_rdy, reply, reply_end, full_n,
    output sample_ack, reply_ack, wr_en, wr_data, ep_adr, pktend
  );

  modport slave (
    output sample_rdy, sample, reply_rdy, reply, reply_end, full_n,
    input  sample_ack, reply_ack, wr_en, wr_data, ep_adr, pktend
  );
endinterface

// File: rtl/fx2_in_scheduler.sv
// rtl/fx2_in_scheduler.sv - arbitrates sample and reply bytes onto the FX2 write path
// Purpose: shares one FX2 slave-FIFO write path between the sample stream and
//          the reply stream. Replies have priority and are committed with
//          PKTEND; partial sample packets are flushed after an idle timeout.
// Ports:
//   fx2_clk  sole clock
//   reset    asynchronous, active-high
//   bus      fx2_in_scheduler_if.master (source handshakes, FX2 write controls)
module fx2_in_scheduler #(
  parameter logic [1:0] SAMPLE_EP     = 2'b00,
  parameter logic [1:0] REPLY_EP      = 2'b10,
  parameter int         BURST         = 512,
  parameter int         PKT_SIZE      = 512,
  parameter int         FLUSH_TIMEOUT = 4096
) (
  input logic                fx2_clk,
  input logic                reset,
  fx2_in_scheduler_if.master bus
);
  localparam int PW = $clog2(PKT_SIZE);
  localparam int BW = $clog2(BURST + 1);
  localparam int IW = $clog2(FLUSH_TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SWITCH, SAMPLE, REPLY, REND, FLUSH} state_t;

  state_t        state, state_nx;
  state_t        target, target_nx;   // state entered once SWITCH completes
  state_t        dest;
  logic [1:0]    ep_q, ep_nx, dest_ep;
  logic          take;
  logic          pktend_q;
  logic [PW-1:0] pkt_cnt;              // wraps at PKT_SIZE like the FX2 auto-commit
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] idle_cnt;
  logic          sample_wr, reply_wr;

  // Zero-latency acceptance: a byte is written in the cycle it is acked.
  assign sample_wr      = (state == SAMPLE) && bus.sample_rdy && bus.full_n;
  assign reply_wr       = (state == REPLY) && bus.reply_rdy && bus.full_n;
  assign bus.wr_en      = sample_wr | reply_wr;
  assign bus.sample_ack = sample_wr;
  assign bus.reply_ack  = reply_wr;
  assign bus.wr_data    = reply_wr ? bus.reply : (sample_wr ? bus.sample : 8'h00);
  assign bus.ep_adr     = ep_q;
  assign bus.pktend     = pktend_q;

  always_comb begin
    state_nx  = state;
    target_nx = target;
    ep_nx     = ep_q;
    dest      = IDLE;
    dest_ep   = ep_q;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reply_rdy) begin
          dest = REPLY;  dest_ep = REPLY_EP;  take = 1'b1;
        end else if (bus.sample_rdy) begin
          dest = SAMPLE; dest_ep = SAMPLE_EP; take = 1'b1;
        end else if ((pkt_cnt != '0) && (idle_cnt == IDLE_MAX)) begin
          dest = FLUSH;  dest_ep = SAMPLE_EP; take = 1'b1;
        end
        // A new FIFOADR needs one setup cycle before the first strobe.
        if (take) begin
          if (dest_ep != ep_q) begin
            state_nx  = SWITCH;
            target_nx = dest;
            ep_nx     = dest_ep;
          end else begin
            state_nx = dest;
          end
        end
      end
      SWITCH: state_nx = target;
      SAMPLE: begin
        // A pending reply leaves after this cycle's write, if one happens.
        if (!bus.sample_rdy || bus.reply_rdy ||
            (sample_wr && (burst_cnt == BURST_LAST)))
          state_nx = IDLE;
      end
      REPLY: begin
        if (reply_wr && bus.reply_end)
          state_nx = REND;
      end
      REND:    state_nx = IDLE;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target    <= IDLE;
      ep_q      <= SAMPLE_EP;
      pktend_q  <= 1'b0;
      pkt_cnt   <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      ep_q     <= ep_nx;
      // Registered so the strobe lines up with the REND/FLUSH cycle.
      pktend_q <= (state_nx == REND) || (state_nx == FLUSH);

      if (state == FLUSH)
        pkt_cnt <= '0;
      else if (sample_wr)
        pkt_cnt <= pkt_cnt + PW'(1);

      if ((state_nx == SAMPLE) && (state != SAMPLE))
        burst_cnt <= '0;
      else if (sample_wr)
        burst_cnt <= burst_cnt + BW'(1);

      // Reply traffic does not reset the flush timer.
      if (sample_wr || (pkt_cnt == '0) || (state == FLUSH))
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + IW'(1);
    end
  end
endmodule

// File: tb/tb_fx2_in_scheduler.sv
// tb/tb_fx2_in_scheduler.sv - self-checking bench for fx2_in_scheduler
module tb_fx2_in_scheduler;
  localparam logic [1:0] SEP   = 2'b00;
  localparam logic [1:0] REP   = 2'b10;
  localparam int         BURST = 512;
  localparam int         PKT   = 512;
  localparam int         FT    = 16;

  logic clk = 1'b0;
  logic rst;

  fx2_in_scheduler_if bus();

  fx2_in_scheduler #(
    .SAMPLE_EP(SEP), .REPLY_EP(REP), .BURST(BURST), .PKT_SIZE(PKT), .FLUSH_TIMEOUT(FT)
  ) dut (
    .fx2_clk(clk),
    .reset  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr, sa, ra, pe, rr, fn;
    logic [1:0] ep;
    logic [7:0] d;
  } rec_t;

  rec_t       tr[$];
  logic [7:0] s_q[$];
  logic [8:0] r_q[$];
  logic [7:0] exp_s[$], exp_r[$], wrote_s[$], wrote_r[$];
  logic [4:0] exp_b [10];

  int  total = 0;
  int  bad   = 0;
  bit  took_s, took_r, prev_rend, force_full;
  int  s_gap, r_gap, full_pct;
  int  m_pkt, m_idle;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  always @(negedge clk) begin
    bit sa, ra, wr, pe, flush_now;
    logic [1:0] ep;
    rec_t r;
    if (rst) begin
      chk("rst_ep_adr", bus.ep_adr, SEP);
      chk("rst_pktend", bus.pktend, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_sample_ack", bus.sample_ack, 0);
      chk("rst_reply_ack", bus.reply_ack, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      m_pkt = 0; m_idle = 0; prev_rend = 0; took_s = 0; took_r = 0;
    end else begin
      wr = bus.wr_en; sa = bus.sample_ack; ra = bus.reply_ack;
      pe = bus.pktend; ep = bus.ep_adr;
      chk("wr_en_vs_ack", wr, sa | ra);
      chk("ack_exclusive", sa & ra, 0);
      if (wr)  chk("write_needs_full_n", bus.full_n, 1);
      if (!wr) chk("wr_data_when_idle", bus.wr_data, 0);
      if (sa) begin
        chk("sample_ack_rdy", bus.sample_rdy, 1);
        chk("sample_data", bus.wr_data, bus.sample);
        chk("sample_ep", ep, SEP);
        wrote_s.push_back(bus.wr_data);
      end
      if (ra) begin
        chk("reply_ack_rdy", bus.reply_rdy, 1);
        chk("reply_data", bus.wr_data, bus.reply);
        chk("reply_ep", ep, REP);
        wrote_r.push_back(bus.wr_data);
      end
      // A reply commit comes exactly one cycle after the end byte.
      chk("reply_pktend", pe && (ep == REP), prev_rend);
      flush_now = pe && (ep == SEP);
      if (flush_now) chk("flush_due", {m_pkt != 0, m_idle == FT - 1}, 2'b11);
      if (pe) chk("pktend_without_write", wr, 0);

      r.wr = wr; r.sa = sa; r.ra = ra; r.pe = pe; r.rr = bus.reply_rdy;
      r.fn = bus.full_n; r.ep = ep; r.d = bus.wr_data;
      tr.push_back(r);

      if (sa || m_pkt == 0 || flush_now) m_idle = 0;
      else if (m_idle < FT - 1)          m_idle++;
      if (flush_now) m_pkt = 0;
      else if (sa)   m_pkt = (m_pkt + 1) % PKT;
      prev_rend = ra && bus.reply_end;
      took_s = sa; took_r = ra;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    logic [8:0] dummy;
    @(posedge clk); #1;
    if (took_s && s_q.size() > 0) dummy = {1'b0, s_q.pop_front()};
    if (took_r && r_q.size() > 0) dummy = r_q.pop_front();
    if (!(bus.sample_rdy && !took_s)) begin
      if (s_q.size() > 0 && $urandom_range(99) >= s_gap) begin
        bus.sample_rdy = 1'b1; bus.sample = s_q[0];
      end else begin
        bus.sample_rdy = 1'b0; bus.sample = 8'h00;
      end
    end
    if (!(bus.reply_rdy && !took_r)) begin
      if (r_q.size() > 0 && $urandom_range(99) >= r_gap) begin
        bus.reply_rdy = 1'b1; bus.reply = r_q[0][7:0]; bus.reply_end = r_q[0][8];
      end else begin
        bus.reply_rdy = 1'b0; bus.reply = 8'h00; bus.reply_end = 1'b0;
      end
    end
    bus.full_n = force_full ? 1'b0 : ($urandom_range(99) >= full_pct);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_samples(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      s_q.push_back(b); exp_s.push_back(b);
    end
  endtask

  task automatic push_rbyte(input logic [7:0] b, input bit e);
    r_q.push_back({e, b}); exp_r.push_back(b);
  endtask

  task automatic clear_sb();
    exp_s.delete(); exp_r.delete(); wrote_s.delete(); wrote_r.delete(); tr.delete();
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((s_q.size() != 0 || r_q.size() != 0) && n < maxc) begin
      tick(); n++;
    end
    chk({nm, "_drain_left"}, s_q.size() + r_q.size(), 0);
  endtask

  task automatic check_streams(input string nm);
    int mis = 0;
    chk({nm, "_sample_count"}, wrote_s.size(), exp_s.size());
    chk({nm, "_reply_count"}, wrote_r.size(), exp_r.size());
    foreach (exp_s[i]) if (i < wrote_s.size() && wrote_s[i] !== exp_s[i]) mis++;
    foreach (exp_r[i]) if (i < wrote_r.size() && wrote_r[i] !== exp_r[i]) mis++;
    chk({nm, "_byte_mismatches"}, mis, 0);
  endtask

  function automatic int count_pe(input logic [1:0] ep);
    int c = 0;
    foreach (tr[i]) if (tr[i].pe && tr[i].ep == ep) c++;
    return c;
  endfunction

  function automatic int count_wr();
    int c = 0;
    foreach (tr[i]) if (tr[i].wr) c++;
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, l, k, n, lw, pi, pc, d, nbad, last0;
    rst = 1'b1; force_full = 0; s_gap = 0; r_gap = 0; full_pct = 0;
    bus.sample_rdy = 0; bus.sample = 0; bus.reply_rdy = 0; bus.reply = 0;
    bus.reply_end = 0; bus.full_n = 1;
    exp_b = '{5'b10000, 5'b00000, 5'b00010, 5'b01010, 5'b01010,
              5'b01010, 5'b00110, 5'b00010, 5'b00000, 5'b10000};
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // A: 1024 continuous samples, one IDLE gap after byte 512
    clear_sb();
    push_samples(1024);
    drain("a", 3000);
    ticks(5);
    f = -1; l = -1; nbad = 0;
    foreach (tr[i]) if (tr[i].wr) begin if (f < 0) f = i; l = i; end
    chk("a_write_count", count_wr(), 1024);
    chk("a_span", l - f, 1024);
    if (f >= 0 && f + 513 < tr.size()) begin
      chk("a_gap_after_512", tr[f+512].wr, 0);
      chk("a_resume_after_gap", tr[f+513].wr, 1);
      for (int i = f; i <= l; i++) if (tr[i].ep != SEP) nbad++;
      chk("a_ep_changes", nbad, 0);
    end else chk("a_trace_found", f, 0);
    chk("a_pktend_count", count_pe(SEP) + count_pe(REP), 0);
    check_streams("a");

    // G: exactly one packet of samples, then a long quiet period
    clear_sb();
    push_samples(512);
    drain("g", 2000);
    ticks(10000);
    chk("g_write_count", count_wr(), 512);
    chk("g_pktend_count", count_pe(SEP) + count_pe(REP), 0);
    check_streams("g");

    // B: reply 41,42,43 raised in the middle of a sample stream
    clear_sb();
    push_samples(40);
    ticks(10);
    push_rbyte(8'h41, 0); push_rbyte(8'h42, 0); push_rbyte(8'h43, 1);
    drain("b", 500);
    ticks(60);
    k = -1;
    foreach (tr[i]) if (k < 0 && tr[i].rr) k = i;
    if (k >= 0 && k + 10 <= tr.size()) begin
      for (int j = 0; j < 10; j++)
        chk($sformatf("b_row%0d", j), {tr[k+j].sa, tr[k+j].ra, tr[k+j].pe, tr[k+j].ep}, exp_b[j]);
      for (int j = 0; j < 3; j++)
        chk($sformatf("b_reply_byte%0d", j), tr[k+3+j].d, 8'h41 + j);
    end else chk("b_reply_seen", k, 0);
    chk("b_reply_pktends", count_pe(REP), 1);
    check_streams("b");

    // C: five samples then silence -> single timeout flush
    clear_sb();
    push_samples(5);
    drain("c", 100);
    ticks(80);
    lw = -1; pi = -1; pc = 0;
    foreach (tr[i]) begin
      if (tr[i].wr) lw = i;
      if (tr[i].pe) begin pc++; pi = i; end
    end
    chk("c_write_count", count_wr(), 5);
    chk("c_pktend_count", pc, 1);
    if (pi >= 0) begin
      chk("c_pktend_ep", tr[pi].ep, SEP);
      d = pi - lw;
      total++;
      if (d < 16 || d > 17) begin
        bad++;
        $display("FAIL c_flush_delay: got %0d want 16..17", d);
      end
    end
    check_streams("c");

    // D: FIFO full for 10 cycles in the middle of a reply
    clear_sb();
    push_rbyte(8'h10, 0); push_rbyte(8'h11, 0); push_rbyte(8'h12, 1);
    n = 0;
    do begin tick(); n++; end while (!took_r && n < 50);
    chk("d_first_reply_write", took_r, 1);
    force_full = 1; bus.full_n = 1'b0;
    ticks(9);
    force_full = 0;
    drain("d", 200);
    ticks(5);
    last0 = -1; nbad = 0;
    foreach (tr[i]) if (!tr[i].fn) begin last0 = i; if (tr[i].wr || tr[i].ra) nbad++; end
    chk("d_writes_during_stall", nbad, 0);
    if (last0 >= 0 && last0 + 1 < tr.size()) begin
      chk("d_resume_ack", tr[last0+1].ra, 1);
      chk("d_resume_data", tr[last0+1].d, 8'h11);
    end else chk("d_stall_seen", last0, 0);
    chk("d_reply_pktends", count_pe(REP), 1);
    check_streams("d");

    // E: reset in the middle of a reply, then a clean 2-byte reply
    clear_sb();
    for (int j = 0; j < 5; j++) push_rbyte(8'h20 + 8'(j), j == 4);
    n = 0;
    do begin tick(); n++; end while (!took_r && n < 50);
    chk("e_reply_started", took_r, 1);
    rst = 1'b1;
    tick();
    r_q.delete(); s_q.delete();
    bus.reply_rdy = 0; bus.reply = 0; bus.reply_end = 0; bus.sample_rdy = 0; bus.sample = 0;
    tick();
    rst = 1'b0;
    clear_sb();
    push_rbyte(8'h31, 0); push_rbyte(8'h32, 1);
    drain("e", 100);
    ticks(5);
    chk("e_reply_pktends", count_pe(REP), 1);
    chk("e_sample_pktends", count_pe(SEP), 0);
    check_streams("e");

    // F: randomized traffic with gaps and back-pressure
    clear_sb();
    s_gap = 20; r_gap = 20; full_pct = 15;
    for (int it = 0; it < 2500; it++) begin
      tick();
      if ($urandom_range(99) < 3) push_samples($urandom_range(60, 1));
      if ($urandom_range(99) < 2 && r_q.size() < 20) begin
        n = $urandom_range(6, 1);
        for (int j = 0; j < n; j++) push_rbyte(8'($urandom), j == n - 1);
      end
    end
    drain("f", 20000);
    s_gap = 0; r_gap = 0; full_pct = 0;
    ticks(40);
    check_streams("f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
